// File: rtl/islip_pkg.sv
// Shared types and helpers for the iSLIP crossbar scheduler.
package islip_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACCEPT = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Width of one port index; never narrower than one bit.
  function automatic int calc_pw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_arbiter.sv
// Combinational rotating-priority pick: first asserted req at or after ptr, circularly.
module rr_priority_arbiter
  import islip_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  localparam int PW        = calc_pw(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PW-1:0]        ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [PW-1:0]        gnt_idx,
  output logic                 any
);

  int          idx;
  logic [PW-1:0] idx_p;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    idx_p   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      idx_p = PW'(idx);
      if (!any && req[idx_p]) begin
        any        = 1'b1;
        gnt[idx_p] = 1'b1;
        gnt_idx    = idx_p;
      end
    end
  end

endmodule

// File: rtl/islip_scheduler.sv
// Multi-iteration iSLIP scheduler: registered request/grant/accept rounds with start/busy/done.
module islip_scheduler
  import islip_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  parameter  int NUM_ITER  = 2,
  localparam int PW        = calc_pw(NUM_PORTS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] request,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_PORTS-1:0]           match_valid,
  output logic [NUM_PORTS*PW-1:0]        destinations
);

  localparam int N  = NUM_PORTS;
  localparam int IW = $clog2(NUM_ITER + 1);

  state_t                 state;
  logic [N-1:0][N-1:0]    req_q;       // [input][output]
  logic [N-1:0][N-1:0]    gnt_q;       // [output] one-hot over inputs
  logic [N-1:0][PW-1:0]   gnt_idx_q;
  logic [N-1:0]           gnt_vld_q;
  logic [N-1:0]           in_matched, out_matched;
  logic [N-1:0][PW-1:0]   in_dst;
  logic [N-1:0][PW-1:0]   grant_ptr, accept_ptr;
  logic [IW-1:0]          iter_cnt, iter_nxt;

  logic [N-1:0][N-1:0]    g_req, g_gnt;   // [output][input]
  logic [N-1:0][PW-1:0]   g_idx;
  logic [N-1:0]           g_any;
  logic [N-1:0][N-1:0]    a_req, a_gnt;   // [input][output]
  logic [N-1:0][PW-1:0]   a_idx;
  logic [N-1:0]           a_any;
  logic [N-1:0]           acc_out;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] x);
    return (int'(x) == N - 1) ? '0 : x + PW'(1);
  endfunction

  always_comb begin
    g_req = '0;
    a_req = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        g_req[j][i] = req_q[i][j] & ~in_matched[i] & ~out_matched[j];
        a_req[i][j] = gnt_vld_q[j] & gnt_q[j][i] & ~in_matched[i];
      end
  end

  always_comb begin
    acc_out = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        acc_out[j] = acc_out[j] | a_gnt[i][j];
  end

  for (genvar p = 0; p < N; p++) begin : g_arb
    rr_priority_arbiter #(.NUM_PORTS(N)) u_grant (
      .req(g_req[p]), .ptr(grant_ptr[p]),
      .gnt(g_gnt[p]), .gnt_idx(g_idx[p]), .any(g_any[p])
    );
    rr_priority_arbiter #(.NUM_PORTS(N)) u_accept (
      .req(a_req[p]), .ptr(accept_ptr[p]),
      .gnt(a_gnt[p]), .gnt_idx(a_idx[p]), .any(a_any[p])
    );
  end

  assign iter_nxt = iter_cnt + IW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      match_valid  <= '0;
      destinations <= '0;
      req_q        <= '0;
      gnt_q        <= '0;
      gnt_idx_q    <= '0;
      gnt_vld_q    <= '0;
      in_matched   <= '0;
      out_matched  <= '0;
      in_dst       <= '0;
      grant_ptr    <= '0;
      accept_ptr   <= '0;
      iter_cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          req_q       <= request;
          in_matched  <= '0;
          out_matched <= '0;
          in_dst      <= '0;
          iter_cnt    <= '0;
          busy        <= 1'b1;
          state       <= GRANT;
        end
        GRANT: begin
          gnt_q     <= g_gnt;
          gnt_idx_q <= g_idx;
          gnt_vld_q <= g_any;
          state     <= ACCEPT;
        end
        ACCEPT: begin
          // Pointers only advance on accepted pairs of the first iteration (starvation freedom).
          for (int i = 0; i < N; i++)
            if (a_any[i]) begin
              in_matched[i] <= 1'b1;
              in_dst[i]     <= a_idx[i];
              if (iter_cnt == '0) accept_ptr[i] <= wrap_inc(a_idx[i]);
            end
          for (int j = 0; j < N; j++)
            if (acc_out[j]) begin
              out_matched[j] <= 1'b1;
              if (iter_cnt == '0) grant_ptr[j] <= wrap_inc(gnt_idx_q[j]);
            end
          iter_cnt <= iter_nxt;
          state    <= (iter_nxt == IW'(NUM_ITER) || !(|a_any)) ? DONE : GRANT;
        end
        DONE: begin
          match_valid <= in_matched;
          for (int i = 0; i < N; i++)
            destinations[i*PW +: PW] <= in_matched[i] ? in_dst[i] : '0;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_islip_scheduler.sv
// Directed + random rounds for islip_scheduler, checked against a behavioural iSLIP model via a scoreboard.
module tb_islip_scheduler;

  localparam int N  = 4;
  localparam int NI = 2;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [N*N-1:0] request = '0;
  logic          busy, done;
  logic [N-1:0]  match_valid;
  logic [N*PW-1:0] destinations;

  always #5 clk = ~clk;

  islip_scheduler #(.NUM_PORTS(N), .NUM_ITER(NI)) dut (
    .clk(clk), .reset(reset), .start(start), .request(request),
    .busy(busy), .done(done), .match_valid(match_valid), .destinations(destinations)
  );

  typedef struct {
    logic [N-1:0]    mv;
    logic [N*PW-1:0] dst;
    int              lat;
  } exp_t;

  exp_t sb[$];
  int   m_gp[N];
  int   m_ap[N];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   last_lat = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference iSLIP round; updates the bench-side pointer copies.
  task automatic model_round(input logic [N*N-1:0] req, output exp_t e);
    logic [N-1:0] mi, mo;
    int gnt[N];
    int dst[N];
    int iters;
    bit newm, stop;
    mi = '0; mo = '0; iters = 0; stop = 0;
    for (int i = 0; i < N; i++) dst[i] = 0;
    for (int it = 0; it < NI; it++) begin
      if (!stop) begin
        for (int j = 0; j < N; j++) begin
          gnt[j] = -1;
          if (!mo[j])
            for (int k = 0; k < N; k++) begin
              int i;
              i = (m_gp[j] + k) % N;
              if (gnt[j] < 0 && !mi[i] && req[i*N+j]) gnt[j] = i;
            end
        end
        newm = 0;
        for (int i = 0; i < N; i++) begin
          int pick;
          pick = -1;
          if (!mi[i]) begin
            for (int k = 0; k < N; k++) begin
              int j;
              j = (m_ap[i] + k) % N;
              if (pick < 0 && gnt[j] == i) pick = j;
            end
            if (pick >= 0) begin
              mi[i] = 1'b1; mo[pick] = 1'b1; dst[i] = pick; newm = 1;
              if (it == 0) begin
                m_ap[i]    = (pick + 1) % N;
                m_gp[pick] = (i + 1) % N;
              end
            end
          end
        end
        iters++;
        if (!newm) stop = 1;
      end
    end
    e.mv  = mi;
    e.dst = '0;
    for (int i = 0; i < N; i++)
      if (mi[i]) e.dst[i*PW +: PW] = PW'(dst[i]);
    e.lat = 2 * iters + 1;
  endtask

  // Wait for done (cycles counted from the accepted start edge), then score it.
  task automatic wait_done(input string tag, input bit disturb);
    int cyc;
    bit got;
    exp_t e;
    cyc = 0; got = 0;
    while (!got && cyc < 40) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 1) check({tag, " busy"}, busy, 1'b1);
      if (disturb && cyc == 2) begin start = 1'b1; request = 16'($urandom); end
      if (disturb && cyc == 3) start = 1'b0;
      if (done) got = 1;
    end
    check({tag, " done seen"}, got, 1'b1);
    last_lat = cyc;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (got) begin
        check({tag, " latency"}, cyc, e.lat);
        check({tag, " match_valid"}, match_valid, e.mv);
        check({tag, " destinations"}, destinations, e.dst);
      end
    end
    @(posedge clk); #1;
    check({tag, " done pulse 1 cycle"}, done, 1'b0);
    check({tag, " busy low"}, busy, 1'b0);
  endtask

  task automatic run_round(input logic [N*N-1:0] req, input string tag, input bit disturb);
    exp_t e;
    model_round(req, e);
    sb.push_back(e);
    request = req;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    wait_done(tag, disturb);
  endtask

  initial begin
    int extra;
    for (int i = 0; i < N; i++) begin m_gp[i] = 0; m_ap[i] = 0; end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst mv", match_valid, 4'b0000);
    check("rst dest", destinations, 8'h00);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle done", done, 1'b0);
    check("idle busy", busy, 1'b0);

    // Empty request
    run_round(16'h0000, "empty", 0);
    check("empty lat", last_lat, 3);
    check("empty mv", match_valid, 4'b0000);

    // All ones, fresh pointers
    run_round(16'hffff, "ones1", 0);
    check("ones1 lat", last_lat, 5);
    check("ones1 mv", match_valid, 4'b0011);
    check("ones1 dest", destinations, 8'h04);

    // All ones again; pointers moved by first iteration only
    run_round(16'hffff, "ones2", 0);
    check("ones2 mv", match_valid, 4'b0111);
    check("ones2 dest", destinations, 8'h21);

    // Permutation i -> (i+1) mod 4
    run_round(16'h1842, "perm", 0);
    check("perm lat", last_lat, 5);
    check("perm mv", match_valid, 4'b1111);
    check("perm dest", destinations, 8'h39);

    // Random patterns
    for (int r = 0; r < 6; r++) run_round(16'($urandom), "rand", 0);

    // Start and request changes mid-round are ignored
    run_round(16'h8421, "midstart", 1);
    check("midstart mv", match_valid, 4'b1111);
    check("midstart dest", destinations, 8'he4);
    extra = 0;
    repeat (10) begin @(posedge clk); #1; if (done) extra++; end
    check("midstart extra done", extra, 0);

    // Reset during ACCEPT of the first iteration
    request = 16'hffff;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 1'b0);
    check("midrst mv", match_valid, 4'b0000);
    check("midrst dest", destinations, 8'h00);
    extra = 0;
    repeat (4) begin @(posedge clk); #1; if (done) extra++; end
    check("midrst no done", extra, 0);
    for (int i = 0; i < N; i++) begin m_gp[i] = 0; m_ap[i] = 0; end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    run_round(16'hffff, "after_rst", 0);
    check("after_rst lat", last_lat, 5);
    check("after_rst mv", match_valid, 4'b0011);
    check("after_rst dest", destinations, 8'h04);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/islip_scheduler.md
Name: islip_scheduler

Overview:
- Parametrised multi-iteration iSLIP crossbar scheduler for an NUM_PORTS x NUM_PORTS input-queued switch.
- Computes a conflict-free input->output matching from a registered request matrix using round-robin grant and accept arbiters.
- Runs up to NUM_ITER request/grant/accept iterations per scheduling round, with start/busy/done handshaking and a match-valid qualifier per input.
- Sits between the virtual-output-queue status logic and the crossbar select registers.

Parameters:
- NUM_PORTS, 4, number of inputs and outputs (>=2).
- NUM_ITER, 2, maximum iSLIP iterations per round (1..NUM_PORTS).
- PW (localparam), max(1,$clog2(NUM_PORTS)), width of one port index.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a round; sampled only when busy=0.
- request  in  NUM_PORTS*NUM_PORTS  request[i*NUM_PORTS+j]=1: input i has a cell for output j.
- busy  out  1  round in progress.
- done  out  1  one-cycle pulse; results valid from this cycle until the next start is accepted.
- match_valid  out  NUM_PORTS  bit i=1: input i matched.
- destinations  out  PW*NUM_PORTS  destinations[i*PW +: PW]=output matched to input i; 0 when match_valid[i]=0.

Behaviour:
- Reset (asynchronous on reset=0):
  - state IDLE; busy, done, match_valid and destinations all 0.
  - All grant_ptr[j] and accept_ptr[i] = 0; iteration counter = 0.
- States: IDLE, GRANT, ACCEPT, DONE.
- IDLE:
  - start=1 latches request into req_q, clears working matches and the iteration counter, sets busy=1, goes to GRANT.
  - start=0: remain in IDLE.
- GRANT (1 cycle):
  - Each unmatched output j considers unmatched inputs i with req_q[i][j]=1.
  - It picks the first such i at or after grant_ptr[j], circularly.
  - The result is registered as a grant matrix.
- ACCEPT (1 cycle):
  - Each unmatched input i considers the grants it received.
  - It picks the first output at or after accept_ptr[i], circularly, and records the match.
- Pointer update, first iteration only, accepted pairs only:
  - accept_ptr[i] = (j+1) mod NUM_PORTS.
  - grant_ptr[j] = (i+1) mod NUM_PORTS.
  - Unaccepted grants do not move pointers.
  - Later iterations never move pointers.
- After ACCEPT:
  - Increment the iteration counter.
  - If counter==NUM_ITER, or this iteration added no new match: go to DONE.
  - Otherwise go to GRANT.
- DONE (1 cycle):
  - match_valid and destinations are updated from the working matches.
  - done=1, busy=0; then go to IDLE.
- Latency: start edge to done = 2*k+1 cycles, where k = iterations executed (k>=1).
- Outputs hold their values until the next round's DONE.
- start while busy=1: ignored.
- request changes after the start edge: ignored until the next round.
- Matching invariants:
  - Each output is assigned to at most one input.
  - Each input is assigned at most one output.
  - A match exists only where req_q=1.
- Reset asserted mid-round: round is abandoned, no done pulse, all state returns to reset values.
- Index arithmetic is modulo NUM_PORTS; the pointer wraps from NUM_PORTS-1 to 0.

Decomposition:
- Shared package/header islip_pkg:
  - State encodings (IDLE=2'd0, GRANT=2'd1, ACCEPT=2'd2, DONE=2'd3).
  - PW computation function.
- Sub-module rr_priority_arbiter:
  - Parameter NUM_PORTS; inputs req[NUM_PORTS] and ptr[PW]; outputs one-hot gnt, gnt_idx and any.
  - Purely combinational rotate-priority pick.
  - Instantiated 2*NUM_PORTS times (one per output for grants, one per input for accepts).
  - Pointer registers live in islip_scheduler.

Test Plan (NUM_PORTS=4, NUM_ITER=2 unless stated):
1. Reset release with no start -> busy=0, done=0, match_valid=4'b0000, destinations=0; start with request=0 -> done 3 cycles after start, match_valid=0, pointers unchanged (next full round behaves as from reset).
2. request all ones, first round after reset -> done 5 cycles after start; in0->out0, in1->out1, match_valid=4'b0011.
3. Same all-ones request, immediate second round -> in0->out1, in1->out0, in2->out2, match_valid=4'b0111 (pointer update only from iteration 1).
4. Permutation request (input i requests output (i+1) mod 4 only) -> iteration 1 matches all four, iteration 2 adds none; done at cycle 5; destinations={0,3,2,1} for in3..in0, match_valid=4'b1111.
5. start pulsed at cycle 2 of a running round, and request changed mid-round -> second start ignored, results reflect the originally latched request, exactly one done pulse.
6. reset driven low during ACCEPT of round 1 -> outputs 0 immediately, no done; after release, the all-ones round reproduces scenario 2 exactly.
